// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (IF) and load/store (LS) share one
// synchronous single-port RAM. LS normally wins; IF is forced through after
// MAX_WAIT consecutive denials. Responses are routed using a registered owner.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic [3:0]            ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [31:0]           if_stall_cnt
);

  localparam int unsigned WaitW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  typedef enum logic [1:0] {OwnNone, OwnIf, OwnLsRd, OwnLsWr} owner_e;

  owner_e            owner_q, owner_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [31:0]       stall_q, stall_d;
  logic              force_if;
  logic              if_denied;

  // Arbitration: LS has priority unless IF has waited MAX_WAIT cycles.
  // Gating with rst keeps grants low while reset is held.
  always_comb begin
    force_if  = if_req && ls_req && (wait_q == WaitMax);
    ls_gnt    = rst && ls_req && !force_if;
    if_gnt    = rst && if_req && !ls_gnt;
    if_denied = if_req && !if_gnt;
  end

  // Memory port mux: drive the winner's request, all zero when idle.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    if (ls_gnt) begin
      mem_en   = 1'b1;
      mem_we   = ls_we;
      mem_addr = ls_addr;
      mem_din  = ls_wdata;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end
  end

  // Next state: starvation counter, stall statistic and access owner.
  always_comb begin
    wait_d  = '0;
    stall_d = stall_q;
    owner_d = OwnNone;
    if (if_denied) begin
      wait_d = (wait_q == WaitMax) ? wait_q : wait_q + WaitW'(1);
      if (stall_q != 32'hFFFF_FFFF) begin
        stall_d = stall_q + 32'd1;
      end
    end
    if (ls_gnt) begin
      owner_d = (ls_we != 4'b0000) ? OwnLsWr : OwnLsRd;
    end else if (if_gnt) begin
      owner_d = OwnIf;
    end
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q  <= '0;
      stall_q <= '0;
      owner_q <= OwnNone;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
      owner_q <= owner_d;
    end
  end

  // Response routing from the registered owner; writes return nothing.
  always_comb begin
    if_rvalid    = (owner_q == OwnIf);
    ls_rvalid    = (owner_q == OwnLsRd);
    if_rdata     = if_rvalid ? mem_dout : '0;
    ls_rdata     = ls_rvalid ? mem_dout : '0;
    if_stall_cnt = stall_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, directed scenarios and a randomized
// phase, all checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic [3:0]    ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic [31:0]   if_stall_cnt;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .if_stall_cnt(if_stall_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM (16 words); reloaded with known contents in reset.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000 + i;
      mem[5]   <= 32'h1122_3344;
      mem_dout <= '0;
    end else if (mem_en) begin
      if (mem_we != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem[mem_addr[3:0]][8*b +: 8] <= mem_din[8*b +: 8];
      end else begin
        mem_dout <= mem[mem_addr[3:0]];
      end
    end
  end

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Reference model state: consecutive IF denials, stall total, pending responses.
  int unsigned m_wait;
  longint      m_stall;
  bit          m_if_pend, m_ls_pend;
  logic [31:0] m_data;
  bit          m_if_gnt, m_ls_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_wait = 0; m_stall = 0; m_if_pend = 0; m_ls_pend = 0; m_data = '0;
  endtask

  // One arbitration cycle, entered and left at a falling edge.
  task automatic cycle(input bit ireq, input logic [AW-1:0] iaddr, input bit lreq,
                       input logic [3:0] lwe, input logic [AW-1:0] laddr,
                       input logic [31:0] lwdata);
    if_req = ireq; if_addr = iaddr;
    ls_req = lreq; ls_we = lwe; ls_addr = laddr; ls_wdata = lwdata;
    #1;
    m_ls_gnt = lreq && !(ireq && m_wait == MW);
    m_if_gnt = ireq && !m_ls_gnt;
    check("if_gnt", 32'(if_gnt), 32'(m_if_gnt));
    check("ls_gnt", 32'(ls_gnt), 32'(m_ls_gnt));
    check("mem_en", 32'(mem_en), 32'(m_if_gnt || m_ls_gnt));
    check("mem_addr", 32'(mem_addr), m_ls_gnt ? 32'(laddr) : m_if_gnt ? 32'(iaddr) : 32'd0);
    check("mem_we", 32'(mem_we), m_ls_gnt ? 32'(lwe) : 32'd0);
    check("mem_din", mem_din, m_ls_gnt ? lwdata : 32'd0);
    check("if_rvalid", 32'(if_rvalid), 32'(m_if_pend));
    check("ls_rvalid", 32'(ls_rvalid), 32'(m_ls_pend));
    check("if_rdata", if_rdata, m_if_pend ? m_data : 32'd0);
    check("ls_rdata", ls_rdata, m_ls_pend ? m_data : 32'd0);
    check("if_stall_cnt", if_stall_cnt, 32'(m_stall));
    // Advance the model to the next cycle.
    m_if_pend = m_if_gnt;
    m_ls_pend = m_ls_gnt && (lwe == 4'b0000);
    m_data    = m_ls_gnt ? mem[laddr[3:0]] : mem[iaddr[3:0]];
    if (ireq && !m_if_gnt) begin
      if (m_wait < MW) m_wait++;
      if (m_stall < 64'hFFFF_FFFF) m_stall++;
    end else begin
      m_wait = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, '0, 0, 4'h0, '0, '0);
  endtask

  initial begin
    bit          h_if, h_ls;
    logic [AW-1:0] h_ia, h_la;
    logic [3:0]  h_we;
    logic [31:0] h_wd;

    // Reset held with both requests asserted: everything quiet.
    rst = 1'b0; if_req = 1'b1; if_addr = '0; ls_req = 1'b1; ls_we = 4'hF;
    ls_addr = '0; ls_wdata = '0;
    model_reset();
    @(negedge clk); #1;
    check("rst_if_gnt", 32'(if_gnt), 0);
    check("rst_ls_gnt", 32'(ls_gnt), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_if_rvalid", 32'(if_rvalid), 0);
    check("rst_ls_rvalid", 32'(ls_rvalid), 0);
    check("rst_stall", if_stall_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // IF-only streaming, addresses 0..3.
    for (int i = 0; i < 4; i++) cycle(1, AW'(i), 0, 4'h0, '0, '0);
    #1 check("ifonly_last_rdata", if_rdata, 32'h1003);
    idle();
    check("ifonly_stall", if_stall_cnt, 0);

    // Contention for 10 cycles: IF forced through every fifth cycle.
    for (int i = 0; i < 10; i++) cycle(1, AW'(8), 1, 4'h0, AW'(9), '0);
    #1 check("contention_stall", if_stall_cnt, 32'd8);
    idle();

    // Partial store then load of the same word.
    cycle(0, '0, 1, 4'b0011, AW'(5), 32'hAABB_CCDD);
    cycle(0, '0, 1, 4'b0000, AW'(5), '0);
    #1 check("store_load_rdata", ls_rdata, 32'h1122_CCDD);
    idle();

    // LS read then IF fetch on the next cycle.
    cycle(0, '0, 1, 4'h0, AW'(2), '0);
    cycle(1, AW'(7), 0, 4'h0, '0, '0);
    #1 check("interleave_if_rdata", if_rdata, 32'h1007);
    idle();

    // Randomized traffic; requesters hold their request until granted.
    h_if = 0; h_ls = 0; h_ia = '0; h_la = '0; h_we = '0; h_wd = '0;
    for (int i = 0; i < 300; i++) begin
      if (!h_if) begin
        h_if = ($urandom_range(0, 2) != 0);
        h_ia = AW'($urandom_range(0, 15));
      end
      if (!h_ls) begin
        h_ls = ($urandom_range(0, 2) != 0);
        h_la = AW'($urandom_range(0, 15));
        h_we = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        h_wd = $urandom;
      end
      cycle(h_if, h_ia, h_ls, h_we, h_la, h_wd);
      if (m_if_gnt) h_if = 0;
      if (m_ls_gnt) h_ls = 0;
    end
    idle();

    // Reset asserted while an IF response is due.
    cycle(1, AW'(3), 0, 4'h0, '0, '0);
    check("pre_reset_if_rvalid", 32'(if_rvalid), 1);
    rst = 1'b0; if_req = 1'b1;
    #1;
    check("midrst_if_rvalid", 32'(if_rvalid), 0);
    check("midrst_if_gnt", 32'(if_gnt), 0);
    check("midrst_stall", if_stall_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    idle();
    idle();

    // Stall counter saturation from just below the top.
    force dut.stall_q = 32'hFFFF_FFFE;
    #1 release dut.stall_q;
    m_stall = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) cycle(1, AW'(1), 1, 4'h0, AW'(4), '0);
    #1 check("sat_value", if_stall_cnt, 32'hFFFF_FFFF);
    idle();
    idle();
    check("sat_hold", if_stall_cnt, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 12, word-address width; DATA_WIDTH, default 32, data width; MAX_WAIT, default 4, consecutive IF denials before a forced IF grant.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge; rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: if_req  in  1  fetch request; if_addr  in  ADDR_WIDTH  fetch word address; if_gnt  out  1  fetch accepted this cycle.
REQ-004 SHALL have ports: if_rvalid  out  1  fetch data valid; if_rdata  out  DATA_WIDTH  fetch data.
REQ-005 SHALL have ports: ls_req  in  1  load/store request; ls_we  in  4  byte write enables, 0 means read; ls_addr  in  ADDR_WIDTH  data word address; ls_wdata  in  DATA_WIDTH  store data; ls_gnt  out  1  load/store accepted this cycle.
REQ-006 SHALL have ports: ls_rvalid  out  1  load data valid; ls_rdata  out  DATA_WIDTH  load data.
REQ-007 SHALL have ports: mem_en  out  1  memory enable; mem_we  out  4  byte enables; mem_addr  out  ADDR_WIDTH  address; mem_din  out  DATA_WIDTH  write data; mem_dout  in  DATA_WIDTH  synchronous read data, valid one cycle after mem_en.
REQ-008 SHALL have port: if_stall_cnt  out  32  saturating count of cycles with if_req high and if_gnt low.

Function
REQ-009 SHALL grant at most one requester per cycle; gnt outputs are combinational from req inputs and registered state.
REQ-010 SHALL grant LS when ls_req=1, unless the forced-IF condition of REQ-012 holds.
REQ-011 SHALL grant IF when if_req=1 and ls_req=0.
REQ-012 SHALL grant IF over LS when if_req=1, ls_req=1, and wait_cnt equals MAX_WAIT.
REQ-013 wait_cnt SHALL increment by 1 on cycles where if_req=1 and if_gnt=0, saturating at MAX_WAIT.
REQ-014 wait_cnt SHALL clear to 0 on every cycle where if_gnt=1, and on every cycle where if_req=0.
REQ-015 On a granted cycle SHALL drive mem_en=1 and the winner's address; mem_we and mem_din SHALL be ls_we/ls_wdata on LS grants and 0 on IF grants.
REQ-016 With no grant SHALL drive mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-017 SHALL register the owner of the access (none, IF, LS-read, LS-write) in a 2-bit owner register each cycle.
REQ-018 SHALL assert if_rvalid exactly one cycle after an IF grant.
REQ-019 SHALL assert ls_rvalid exactly one cycle after an LS grant with ls_we=0.
REQ-020 LS writes SHALL produce no rvalid.
REQ-021 if_rdata and ls_rdata SHALL equal mem_dout when their rvalid is high, and 0 otherwise.
REQ-022 SHALL sustain back-to-back grants every cycle with no bubble; a response and a new grant SHALL coexist in the same cycle.
REQ-023 Requesters hold req, address and data stable until gnt; the arbiter SHALL NOT buffer requests.
REQ-024 if_stall_cnt SHALL saturate at 32'hFFFF_FFFF and not wrap.

Reset
REQ-025 rst=0 SHALL asynchronously clear wait_cnt, the owner register and if_stall_cnt.
REQ-026 While rst=0, all gnt and rvalid outputs, mem_en and mem_we SHALL be 0.
REQ-027 A response pending when reset asserts SHALL be discarded; no rvalid after reset release without a new grant.
REQ-028 Requests SHALL be arbitrated on the first rising edge after reset deasserts.

Verification
REQ-029 IF-only: if_req=1, addrs 0..3, mem preloaded 0x1000+i -> if_gnt every cycle; if_rvalid one cycle later with if_rdata=0x1000..0x1003; if_stall_cnt=0.
REQ-030 Contention, MAX_WAIT=4: if_req=1 and ls_req=1 held 10 cycles -> LS granted cycles 0-3, IF cycle 4, LS cycles 5-8, IF cycle 9; if_stall_cnt=8.
REQ-031 Store then load: ls_we=4'b0011, addr 5, wdata 0xAABBCCDD over 0x11223344, then read addr 5 -> no rvalid for store; ls_rvalid next cycle with ls_rdata=0x1122CCDD.
REQ-032 Interleave: LS read addr 2, then IF addr 7 on the following cycle -> ls_rvalid then if_rvalid on consecutive cycles, each with the correct data and the other rvalid low.
REQ-033 Reset mid-operation: assert rst=0 in the cycle after an IF grant -> if_rvalid=0 immediately and stays 0 after release; if_stall_cnt=0.
REQ-034 Saturation: force if_stall_cnt near max (0xFFFF_FFFE) with IF starved 3 cycles -> reads 0xFFFF_FFFF and holds.
